// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared constants and types for the JPEG DCT datapath
package jpeg_pkg;

    localparam int JPEG_N = 8;
    localparam int COEF_W = 12;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } bank_state_t;

    typedef logic [JPEG_N*COEF_W-1:0] coef_row_t;

    function automatic logic bank_writable(input bank_state_t s);
        return (s == EMPTY) || (s == FILL);
    endfunction

    function automatic logic bank_readable(input bank_state_t s);
        return (s == FULL) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/tp_bank.sv
// rtl/tp_bank.sv - one NxN transpose bank: row write port, column read mux
module tp_bank
    import jpeg_pkg::*;
#(
    parameter int W = COEF_W,
    parameter int N = JPEG_N
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        we,
    input  logic [$clog2(N)-1:0]        waddr,
    input  logic [N*W-1:0]              wdata,
    input  logic [$clog2(N)-1:0]        rcol,
    output logic [N*W-1:0]              rdata
);

    logic [N*W-1:0] mem [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Element r of the output word is column rcol of stored row r.
    always_comb begin
        rdata = '0;
        for (int r = 0; r < N; r++) begin
            rdata[W*r +: W] = mem[r][W*int'(rcol) +: W];
        end
    end

endmodule

// File: rtl/transpose_pp.sv
// rtl/transpose_pp.sv - ping-pong 8x8 transpose buffer between row and column DCT
module transpose_pp
    import jpeg_pkg::*;
#(
    parameter int W = COEF_W,
    parameter int N = JPEG_N
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*W-1:0]  out_data,
    output logic            out_last
);

    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] CNT_LAST = AW'(N - 1);

    bank_state_t    state_q [2];
    bank_state_t    state_d [2];
    logic           wbank_q, wbank_d;
    logic           rbank_q, rbank_d;
    logic [AW-1:0]  wcnt_q, wcnt_d;
    logic [AW-1:0]  rcnt_q, rcnt_d;
    logic           wr_fire, rd_fire;
    logic [N*W-1:0] col_data [2];

    // Handshake flags decode registered state only, so in_ready never depends on out_ready.
    assign in_ready  = bank_writable(state_q[wbank_q]);
    assign out_valid = bank_readable(state_q[rbank_q]);
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;
    assign out_last  = out_valid && (rcnt_q == CNT_LAST);
    assign out_data  = out_valid ? col_data[rbank_q] : '0;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        tp_bank #(
            .W(W),
            .N(N)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (wr_fire && !clr && (wbank_q == 1'(b))),
            .waddr (wcnt_q),
            .wdata (in_data),
            .rcol  (rcnt_q),
            .rdata (col_data[b])
        );
    end

    // Write and read fires never share a bank (writable vs readable states), so they update independently.
    always_comb begin
        state_d[0] = state_q[0];
        state_d[1] = state_q[1];
        wbank_d    = wbank_q;
        rbank_d    = rbank_q;
        wcnt_d     = wcnt_q;
        rcnt_d     = rcnt_q;
        if (clr) begin
            state_d[0] = EMPTY;
            state_d[1] = EMPTY;
            wbank_d    = 1'b0;
            rbank_d    = 1'b0;
            wcnt_d     = '0;
            rcnt_d     = '0;
        end else begin
            if (wr_fire) begin
                if (wcnt_q == CNT_LAST) begin
                    state_d[wbank_q] = FULL;
                    wcnt_d           = '0;
                    wbank_d          = ~wbank_q;
                end else begin
                    state_d[wbank_q] = FILL;
                    wcnt_d           = wcnt_q + 1'b1;
                end
            end
            if (rd_fire) begin
                if (rcnt_q == CNT_LAST) begin
                    state_d[rbank_q] = EMPTY;
                    rcnt_d           = '0;
                    rbank_d          = ~rbank_q;
                end else begin
                    state_d[rbank_q] = DRAIN;
                    rcnt_d           = rcnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            wbank_q    <= wbank_d;
            rbank_q    <= rbank_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
        end
    end

    // Producer must hold a stalled row steady until it is taken.
    a_in_stable: assert property (@(posedge clk) disable iff (!rst_n || clr)
        (in_valid && !in_ready) |=> (!in_valid || $stable(in_data)));

    a_no_bank_overlap: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_fire && rd_fire && (wbank_q == rbank_q)));

endmodule

// File: doc/transpose_pp.md
Name: transpose_pp

Overview:
- Double-buffered (ping-pong) 8x8 transpose buffer for the JPEG DCT datapath.
- Accepts one 8-element row per transfer from the row-DCT stage.
- Emits one 8-element column per transfer to the column-DCT/quantiser stage.
- Both sides use valid/ready handshakes, so filling one bank overlaps draining the other.

Parameters:
- W, 12, element width in bits.
- N, 8, block dimension (rows = columns = elements per word); only N=8 is verified.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear; discards both banks and all counters.
- in_valid  in  1  in_data holds a valid row.
- in_ready  out  1  buffer can accept a row this cycle.
- in_data  in  N*W  row r; element c at bits [W*c+W-1 : W*c].
- out_valid  out  1  out_data holds a valid column.
- out_ready  in  1  consumer accepts the column this cycle.
- out_data  out  N*W  column c; element r at bits [W*r+W-1 : W*r].
- out_last  out  1  high together with out_valid on column N-1 of a block.

Behaviour:
- Storage: two banks, each N rows x N*W bits; all storage flops reset to 0.
- Bank state (2-bit enum): EMPTY, FILL, FULL, DRAIN.
- Pointers: wbank (1b) with wcnt (0..N-1); rbank (1b) with rcnt (0..N-1).
- Reset values: both banks EMPTY; wbank = rbank = 0; wcnt = rcnt = 0; in_ready = 1; out_valid = 0; out_last = 0; out_data = 0.
- in_ready = (state[wbank] is EMPTY or FILL). It is a registered-state decode only, with no combinational path from out_ready.
- Write fire = in_valid & in_ready:
  - in_data is stored into row wcnt of bank wbank; bank moves to FILL.
  - On the fire with wcnt = N-1: bank becomes FULL, wcnt wraps to 0, wbank toggles.
- out_valid = (state[rbank] is FULL or DRAIN).
- out_data = column rcnt of bank rbank, i.e. element r = bank[rbank][row r][col rcnt].
  - out_data is a combinational mux from registered storage, stable while out_valid & !out_ready.
- out_last = out_valid & (rcnt = N-1).
- Read fire = out_valid & out_ready:
  - Bank moves to DRAIN and rcnt increments.
  - On the fire with rcnt = N-1: bank becomes EMPTY, rcnt wraps to 0, rbank toggles.
- Latency: first column is valid the cycle after the N-th row fires; no bubble between consecutive blocks.
- Throughput: 1 row/cycle in and 1 column/cycle out when both sides stream.
- Simultaneous write and read fire in the same cycle:
  - They always target different banks, except when both banks are EMPTY/FULL-idle.
  - Both updates apply independently.
- A bank freed by the last read becomes writable the following cycle (in_ready sees the registered EMPTY).
- Both banks FULL: in_ready = 0, so in_data is ignored and storage is unchanged.
- Both banks EMPTY: out_valid = 0; out_ready is ignored.
- in_valid deassertion mid-block: wcnt holds and the partial bank stays FILL indefinitely (not readable).
- clr: same end state as reset except storage contents; it takes priority over any fire in that cycle.
- rst_n asserted mid-block: everything returns to reset values immediately; partial data is lost.
- Protocol assumption checked by assertions: in_data stable while in_valid & !in_ready.

Decomposition:
- Shared package jpeg_pkg holds: constant JPEG_N = 8, constant COEF_W = 12, typedef bank_state_t (EMPTY/FILL/FULL/DRAIN), typedef coef_row_t = logic [N*W-1:0].
- One natural sub-module, tp_bank: one N x N*W storage array with a row write port and a column read mux (instantiated twice).
- Pointer and state control live in transpose_pp.

Test Plan:
- Single block:
  - Write rows r=0..7 with element c = 12'h0rc, out_ready=1.
  - Expect columns c=0..7, each element r = 12'h0rc.
  - First out_valid one cycle after the 8th row fires; out_last only on c=7.
- Back-to-back streaming:
  - 4 blocks, in_valid and out_ready held at 1.
  - Expect in_ready constantly 1 after the first block, and exactly 32 columns with no gaps after the first out_valid.
- Backpressure:
  - out_ready=0 while writing 3 blocks.
  - After 16 row fires, in_ready=0 and the 17th row is not accepted.
  - Releasing out_ready yields block 0 then block 1 intact; in_ready rises the cycle after column 7 of block 0 fires.
- Random stalls:
  - Random in_valid/out_ready (50%) over 20 blocks with a scoreboard.
  - Expect every column to match the transpose; out_data stable while stalled.
- Mid-block clear:
  - clr after 5 rows of block A.
  - Expect out_valid stays 0; in_ready=1; the next 8 rows form a clean block whose column 0 = rows' element 0.
- Async reset mid-drain:
  - Assert rst_n=0 after 3 columns are read.
  - Expect out_valid=0, out_data=0, in_ready=1 immediately, without waiting for a clock edge.
